// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder: collects up to eight operands into registered slots and
// presents them to an adder tree as one batch, zero-padding short batches.
module adder_tree_feeder #(
  parameter int ADDER_WIDTH  = 128,
  parameter int NUM_OPERANDS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDER_WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic [ADDER_WIDTH-1:0] isum0_0_0_0,
  output logic [ADDER_WIDTH-1:0] isum0_0_0_1,
  output logic [ADDER_WIDTH-1:0] isum0_0_1_0,
  output logic [ADDER_WIDTH-1:0] isum0_0_1_1,
  output logic [ADDER_WIDTH-1:0] isum0_1_0_0,
  output logic [ADDER_WIDTH-1:0] isum0_1_0_1,
  output logic [ADDER_WIDTH-1:0] isum0_1_1_0,
  output logic [ADDER_WIDTH-1:0] isum0_1_1_1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_count
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [ADDER_WIDTH-1:0] slot_q [NUM_OPERANDS];
  logic [ADDER_WIDTH-1:0] slot_d [NUM_OPERANDS];
  logic accept, close;
  assign accept = in_valid & in_ready_q;
  assign close  = accept & (in_last | (idx_q == 3'd7));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == FILL) state_d = close ? HOLD : FILL;
    else                 state_d = out_ready ? FILL : HOLD;
  end
  // Handshake flags are registered copies of the next state, so in_ready stays low
  // for the first cycle after reset and rises on the first edge.
  always_comb begin
    in_ready_d  = (state_d == FILL);
    out_valid_d = (state_d == HOLD);
    idx_d       = close ? 3'd0 : accept ? idx_q + 3'd1 : idx_q;
    cnt_d       = close ? {1'b0, idx_q} + 4'd1 : cnt_q;
    for (int j = 0; j < NUM_OPERANDS; j++) begin
      slot_d[j] = slot_q[j];
      if (accept && 3'(j) == idx_q) slot_d[j] = in_data;
      else if (close && 3'(j) > idx_q) slot_d[j] = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int j = 0; j < NUM_OPERANDS; j++) slot_q[j] <= '0;
    end else begin
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int j = 0; j < NUM_OPERANDS; j++) slot_q[j] <= slot_d[j];
    end
  end
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_count   = cnt_q;
  assign isum0_0_0_0 = slot_q[0];
  assign isum0_0_0_1 = slot_q[1];
  assign isum0_0_1_0 = slot_q[2];
  assign isum0_0_1_1 = slot_q[3];
  assign isum0_1_0_0 = slot_q[4];
  assign isum0_1_0_1 = slot_q[5];
  assign isum0_1_1_0 = slot_q[6];
  assign isum0_1_1_1 = slot_q[7];
endmodule

// File: tb/tb_adder_tree_feeder.sv
// tb_adder_tree_feeder: directed scenarios plus randomized traffic checked
// against a batch-level queue model of the feeder.
module tb_adder_tree_feeder;
  logic clk = 0, rst, in_valid, in_last, out_ready;
  logic [127:0] in_data;
  logic in_ready, out_valid;
  logic [3:0] out_count;
  logic [127:0] s0, s1, s2, s3, s4, s5, s6, s7;
  logic [127:0] s [8];
  int cmp = 0, bad = 0;
  always #5 clk = ~clk;
  adder_tree_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .isum0_0_0_0(s0), .isum0_0_0_1(s1), .isum0_0_1_0(s2),
    .isum0_0_1_1(s3), .isum0_1_0_0(s4), .isum0_1_0_1(s5), .isum0_1_1_0(s6),
    .isum0_1_1_1(s7), .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );
  assign s[0] = s0; assign s[1] = s1; assign s[2] = s2; assign s[3] = s3;
  assign s[4] = s4; assign s[5] = s5; assign s[6] = s6; assign s[7] = s7;
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // One clock cycle: drive at the falling edge, report the handshakes that the
  // following rising edge will complete, return at the next falling edge.
  task automatic drive(input logic v, input logic [127:0] d, input logic l, input logic r,
                       output bit acc, output bit xfer);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    acc  = v && (in_ready === 1'b1);
    xfer = r && (out_valid === 1'b1);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1; in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_count !== 4'd0) begin
      bad++; $display("FAIL reset_ctrl: in_ready=%b out_valid=%b out_count=%0d want 0/0/0", in_ready, out_valid, out_count);
    end
    for (int i = 0; i < 8; i++) begin
      cmp++;
      if (s[i] !== '0) begin bad++; $display("FAIL reset_slot%0d: got %h want 0", i, s[i]); end
    end
    rst = 0;
    #1 cmp++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_release_early: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    cmp++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release: in_ready=%b want 1", in_ready); end
  endtask
  task automatic test_full();
    bit a, x;
    int n = 0;
    for (int i = 0; i < 8; i++) begin drive(1, 128'(i + 1), 0, 0, a, x); n += int'(a); end
    cmp++;
    if (n != 8) begin bad++; $display("FAIL full_accepts: got %0d want 8", n); end
    cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 4'd8) begin
      bad++; $display("FAIL full_ctrl: out_valid=%b in_ready=%b out_count=%0d want 1/0/8", out_valid, in_ready, out_count);
    end
    for (int i = 0; i < 8; i++) begin
      cmp++;
      if (s[i] !== 128'(i + 1)) begin bad++; $display("FAIL full_slot%0d: got %h want %0d", i, s[i], i + 1); end
    end
    drive(0, '0, 0, 1, a, x);
    cmp++;
    if (!x || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL full_xfer: xfer=%b in_ready=%b out_valid=%b want 1/1/0", x, in_ready, out_valid);
    end
  endtask
  task automatic test_early_and_stall();
    bit a, x;
    logic [127:0] e [8];
    e[0] = 128'hA; e[1] = 128'hB; e[2] = 128'hC;
    for (int i = 3; i < 8; i++) e[i] = '0;
    for (int i = 0; i < 3; i++) drive(1, e[i], i == 2, 0, a, x);
    cmp++;
    if (out_valid !== 1'b1 || out_count !== 4'd3) begin
      bad++; $display("FAIL early_ctrl: out_valid=%b out_count=%0d want 1/3", out_valid, out_count);
    end
    for (int i = 0; i < 8; i++) begin
      cmp++;
      if (s[i] !== e[i]) begin bad++; $display("FAIL early_slot%0d: got %h want %h", i, s[i], e[i]); end
    end
    for (int c = 0; c < 5; c++) begin
      drive(1, rnd128(), 1'($urandom), 0, a, x);
      cmp++;
      if (a || out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 4'd3) begin
        bad++; $display("FAIL stall_ctrl: acc=%b out_valid=%b in_ready=%b out_count=%0d want 0/1/0/3", a, out_valid, in_ready, out_count);
      end
      for (int i = 0; i < 8; i++) begin
        cmp++;
        if (s[i] !== e[i]) begin bad++; $display("FAIL stall_slot%0d: got %h want %h", i, s[i], e[i]); end
      end
    end
    drive(1, 128'hDEAD, 0, 1, a, x);
    cmp++;
    if (!x || a || in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release: xfer=%b acc=%b in_ready=%b want 1/0/1", x, a, in_ready);
    end
    drive(1, 128'h77, 0, 0, a, x);
    drive(1, 128'h88, 1, 0, a, x);
    cmp++;
    if (out_count !== 4'd2 || s[0] !== 128'h77 || s[1] !== 128'h88 || s[2] !== '0) begin
      bad++; $display("FAIL restart_index: count=%0d s0=%h s1=%h s2=%h want 2/77/88/0", out_count, s[0], s[1], s[2]);
    end
    drive(0, '0, 0, 1, a, x);
  endtask
  task automatic test_single();
    bit a, x;
    drive(1, 128'h5, 1, 0, a, x);
    cmp++;
    if (out_valid !== 1'b1 || out_count !== 4'd1 || s[0] !== 128'h5) begin
      bad++; $display("FAIL single: out_valid=%b count=%0d s0=%h want 1/1/5", out_valid, out_count, s[0]);
    end
    for (int i = 1; i < 8; i++) begin
      cmp++;
      if (s[i] !== '0) begin bad++; $display("FAIL single_slot%0d: got %h want 0", i, s[i]); end
    end
    drive(0, '0, 0, 1, a, x);
  endtask
  task automatic test_back_to_back();
    bit a, x;
    int sent = 0;
    int pulses [$];
    for (int c = 0; c < 30; c++) begin
      if (out_valid === 1'b1) begin
        pulses.push_back(c);
        cmp++;
        if (out_count !== 4'd8) begin bad++; $display("FAIL b2b_count: got %0d want 8", out_count); end
        for (int i = 0; i < 8; i++) begin
          cmp++;
          if (s[i] !== '1) begin bad++; $display("FAIL b2b_slot%0d: got %h want all ones", i, s[i]); end
        end
      end
      drive(sent < 16, '1, sent == 15, 1, a, x);
      sent += int'(a);
    end
    cmp++;
    if (pulses.size() != 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses.size()); end
    else begin
      cmp++;
      if (pulses[1] - pulses[0] != 9) begin bad++; $display("FAIL b2b_spacing: got %0d want 9", pulses[1] - pulses[0]); end
    end
  endtask
  task automatic test_reset_mid();
    bit a, x;
    logic [127:0] e [8];
    for (int i = 0; i < 4; i++) drive(1, rnd128(), 0, 0, a, x);
    #2 rst = 1;
    #1 cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_count !== 4'd0) begin
      bad++; $display("FAIL midrst_ctrl: in_ready=%b out_valid=%b count=%0d want 0/0/0", in_ready, out_valid, out_count);
    end
    for (int i = 0; i < 8; i++) begin
      cmp++;
      if (s[i] !== '0) begin bad++; $display("FAIL midrst_slot%0d: got %h want 0", i, s[i]); end
    end
    @(negedge clk); rst = 0;
    for (int c = 0; c < 3; c++) begin
      drive(0, '0, 0, 1, a, x);
      cmp++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_novalid: out_valid=%b want 0", out_valid); end
    end
    for (int i = 0; i < 8; i++) begin e[i] = rnd128(); drive(1, e[i], 0, 0, a, x); end
    cmp++;
    if (out_valid !== 1'b1 || out_count !== 4'd8) begin
      bad++; $display("FAIL midrst_batch: out_valid=%b count=%0d want 1/8", out_valid, out_count);
    end
    for (int i = 0; i < 8; i++) begin
      cmp++;
      if (s[i] !== e[i]) begin bad++; $display("FAIL midrst_slot%0d_data: got %h want %h", i, s[i], e[i]); end
    end
    #2 rst = 1;
    #1 cmp++;
    if (out_valid !== 1'b0 || s[0] !== '0) begin
      bad++; $display("FAIL holdrst: out_valid=%b s0=%h want 0/0", out_valid, s[0]);
    end
    @(negedge clk); rst = 0;
    for (int c = 0; c < 3; c++) begin
      drive(0, '0, 0, 1, a, x);
      cmp++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL holdrst_novalid: out_valid=%b want 0", out_valid); end
    end
  endtask
  // Model: accepted words queue up; a batch closes at eight words or on in_last
  // and is expected verbatim, zero-padded, until the consumer takes it.
  task automatic test_random();
    bit a, x, have = 0;
    logic [127:0] q [$];
    logic [127:0] e [8];
    int n = 0;
    for (int c = 0; c < 600; c++) begin
      logic v, l, r;
      logic [127:0] d;
      v = ($urandom_range(0, 3) != 0); l = ($urandom_range(0, 5) == 0);
      r = 1'($urandom); d = rnd128();
      cmp++;
      if (out_valid !== have || in_ready !== !have) begin
        bad++; $display("FAIL rand_ctrl: cyc %0d out_valid=%b in_ready=%b want %b/%b", c, out_valid, in_ready, have, !have);
      end
      if (have) begin
        cmp++;
        if (out_count !== 4'(n)) begin bad++; $display("FAIL rand_count: cyc %0d got %0d want %0d", c, out_count, n); end
        for (int i = 0; i < 8; i++) begin
          cmp++;
          if (s[i] !== e[i]) begin bad++; $display("FAIL rand_slot%0d: cyc %0d got %h want %h", i, c, s[i], e[i]); end
        end
      end
      drive(v, d, l, r, a, x);
      if (x) have = 0;
      if (a) begin
        q.push_back(d);
        if (q.size() == 8 || l) begin
          n = q.size();
          for (int i = 0; i < 8; i++) e[i] = (i < n) ? q[i] : '0;
          q.delete();
          have = 1;
        end
      end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t want < 2000000", $time);
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_full();
    test_early_and_stall();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
